// File: rtl/div.sv
// ----------------------------------------------------------------------------
// div -- 32-bit iterative restoring divider, signed (DIV) or unsigned (DIVU).
//
// One quotient bit is produced per clock. A request is accepted in FREE,
// runs for 32 iteration edges in ON, and the sign-corrected result is
// registered on the following edge. The result is then held in END until
// the requester drops start_i. A zero divisor skips the iterations and
// yields an all-zero result.
//
// Ports
//   clk           in   1   clock, all state updates on the rising edge
//   rst           in   1   synchronous, active-high reset
//   signed_div_i  in   1   1 = signed divide, 0 = unsigned divide
//   opdata1_i     in  32   dividend
//   opdata2_i     in  32   divisor
//   start_i       in   1   request, held high until ready_o is seen
//   annul_i       in   1   cancel the in-flight division
//   result_o      out 64   {remainder[63:32], quotient[31:0]}
//   ready_o       out  1   result_o is valid
//   stallreq_o    out  1   stall request, start_i & ~ready_o
//
// State   | meaning
// --------+-----------------------------------------------------------------
// FREE    | idle, outputs zero, waiting for start_i
// BYZERO  | divisor was zero, zero result is produced on the next edge
// ON      | iterating; cnt counts completed quotient bits (0..32)
// END     | result valid, held until start_i drops
// ----------------------------------------------------------------------------
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stallreq_o
);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t      state_q,    state_d;
    logic [5:0]  cnt_q,      cnt_d;
    logic [64:0] dividend_q, dividend_d;
    logic [31:0] divisor_q,  divisor_d;
    logic        neg_quo_q,  neg_quo_d;
    logic        neg_rem_q,  neg_rem_d;
    logic [63:0] result_q,   result_d;
    logic        ready_q,    ready_d;

    logic [31:0] op1_abs;
    logic [31:0] op2_abs;
    logic [32:0] diff;
    logic [31:0] quo_raw;
    logic [31:0] rem_raw;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign op1_abs = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    assign op2_abs = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

    // Trial subtraction of the divisor from the current partial remainder;
    // bit 32 set means the subtraction borrowed and the quotient bit is 0.
    assign diff = {1'b0, dividend_q[63:32]} - {1'b0, divisor_q};

    assign quo_raw = dividend_q[31:0];
    assign rem_raw = dividend_q[64:33];
    assign quo_fix = neg_quo_q ? (~quo_raw + 32'd1) : quo_raw;
    assign rem_fix = neg_rem_q ? (~rem_raw + 32'd1) : rem_raw;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;

        case (state_q)
            FREE: begin
                ready_d  = 1'b0;
                result_d = 64'h0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == 32'h0) begin
                        state_d = BYZERO;
                    end else begin
                        state_d    = ON;
                        cnt_d      = 6'd0;
                        dividend_d = {32'h0, op1_abs, 1'b0};
                        divisor_d  = op2_abs;
                        // Signs are latched here so that the final correction
                        // does not depend on the operand inputs later on.
                        neg_quo_d  = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                        neg_rem_d  = signed_div_i & opdata1_i[31];
                    end
                end
            end

            BYZERO: begin
                dividend_d = 65'h0;
                result_d   = 64'h0;
                ready_d    = 1'b1;
                state_d    = END;
            end

            ON: begin
                if (annul_i || !start_i) begin
                    state_d  = FREE;
                    cnt_d    = 6'd0;
                    ready_d  = 1'b0;
                    result_d = 64'h0;
                end else if (cnt_q != 6'd32) begin
                    if (diff[32]) begin
                        dividend_d = {dividend_q[63:0], 1'b0};
                    end else begin
                        dividend_d = {diff[31:0], dividend_q[31:0], 1'b1};
                    end
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    result_d = {rem_fix, quo_fix};
                    ready_d  = 1'b1;
                    state_d  = END;
                    cnt_d    = 6'd0;
                end
            end

            END: begin
                if (!start_i) begin
                    state_d  = FREE;
                    ready_d  = 1'b0;
                    result_d = 64'h0;
                end
            end

            default: begin
                state_d = FREE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FREE;
            cnt_q      <= 6'd0;
            dividend_q <= 65'h0;
            divisor_q  <= 32'h0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= 64'h0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    assign stallreq_o = start_i & ~ready_q;

endmodule

// File: tb/tb_div.sv
// ----------------------------------------------------------------------------
// tb_div -- self-checking bench for div. A table of directed divisions with
// hand-computed results is run through a common request/handshake task, then
// a few hand-written sequences cover annul, start drop and reset mid-ON.
// ----------------------------------------------------------------------------
module tb_div;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int n_cmp;
    int n_err;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check_hex(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request, waits (bounded) for ready_o, checks latency, stall
    // length, result, END hold with start high, and the return to FREE.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input int exp_lat, input string name);
        int edges;
        int stalls;
        bit got;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        #1;
        stalls = int'(stallreq_o);
        edges  = 0;
        got    = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            tick();
            edges++;
            stalls += int'(stallreq_o);
            if (ready_o) got = 1'b1;
        end
        check_int({name, " latency"}, got ? edges : -1, exp_lat);
        check_int({name, " stall cycles"}, stalls, exp_lat);
        check_hex({name, " result"}, result_o, exp);
        tick();
        check_hex({name, " END hold ready"}, {63'h0, ready_o}, 64'h1);
        check_hex({name, " END hold result"}, result_o, exp);
        start_i = 1'b0;
        tick();
        check_hex({name, " release ready"}, {63'h0, ready_o}, 64'h0);
        check_hex({name, " release result"}, result_o, 64'h0);
    endtask

    task automatic watch_no_ready(input int cycles, input string name);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (ready_o) seen++;
        end
        check_int({name, " ready cycles"}, seen, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        vecs[0]  = '{1'b0, 32'd100,       32'd7,          {32'h2,        32'hE},        34};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,  32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD}, 34};
        vecs[2]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF,   {32'h0,        32'h80000000}, 34};
        vecs[3]  = '{1'b0, 32'hFFFFFFFF,  32'd1,          {32'h0,        32'hFFFFFFFF}, 34};
        vecs[4]  = '{1'b0, 32'h00001234,  32'd0,          64'h0,                        2};
        vecs[5]  = '{1'b1, 32'h00001234,  32'd0,          64'h0,                        2};
        vecs[6]  = '{1'b0, 32'hFFFFFFF9,  32'd2,          {32'h1,        32'h7FFFFFFC}, 34};
        vecs[7]  = '{1'b1, 32'd7,         32'hFFFFFFFE,   {32'h1,        32'hFFFFFFFD}, 34};
        vecs[8]  = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,   {32'hFFFFFFFE, 32'h0000000E}, 34};
        vecs[9]  = '{1'b0, 32'd5,         32'd10,         {32'h5,        32'h0},        34};
        vecs[10] = '{1'b0, 32'hDEADBEEF,  32'h10,         {32'hF,        32'h0DEADBEE}, 34};
        vecs[11] = '{1'b0, 32'h80000000,  32'hFFFFFFFF,   {32'h80000000, 32'h0},        34};

        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'h0;
        opdata2_i    = 32'h0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        tick();
        tick();
        check_hex("reset ready", {63'h0, ready_o}, 64'h0);
        check_hex("reset result", result_o, 64'h0);
        check_hex("reset stall", {63'h0, stallreq_o}, 64'h0);

        // Request while in reset: stall follows start, nothing starts.
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        #1;
        check_hex("reset stall follows start", {63'h0, stallreq_o}, 64'h1);
        for (int i = 0; i < 36; i++) tick();
        check_hex("reset holds ready low", {63'h0, ready_o}, 64'h0);
        start_i = 1'b0;
        rst     = 1'b0;
        tick();

        for (int v = 0; v < 12; v++) begin
            run_div(vecs[v].sgn, vecs[v].a, vecs[v].b, vecs[v].exp, vecs[v].lat,
                    $sformatf("vec%0d", v));
            tick();
        end

        // Annul mid-ON: no result, then a fresh division completes normally.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        repeat (10) tick();
        annul_i = 1'b1;
        tick();
        check_hex("annul ready", {63'h0, ready_o}, 64'h0);
        check_hex("annul result", result_o, 64'h0);
        annul_i = 1'b0;
        start_i = 1'b0;
        watch_no_ready(40, "annul");
        run_div(1'b0, 32'hFFFFFFFF, 32'd1, {32'h0, 32'hFFFFFFFF}, 34, "after annul");
        tick();

        // Start dropped mid-ON aborts the division.
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        repeat (5) tick();
        start_i = 1'b0;
        watch_no_ready(40, "start drop");

        // Reset mid-ON, then a restarted 100/7 with normal latency.
        start_i = 1'b1;
        repeat (20) tick();
        rst = 1'b1;
        tick();
        check_hex("midrst ready", {63'h0, ready_o}, 64'h0);
        check_hex("midrst result", result_o, 64'h0);
        check_hex("midrst stall", {63'h0, stallreq_o}, 64'h1);
        rst     = 1'b0;
        start_i = 1'b0;
        tick();
        run_div(1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 34, "after midrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
